// File: rtl/conv_pass_sequencer_if.sv
// ============================================================================
// Module      : conv_pass_sequencer_if
// Description : Bundle of every non-clock/reset signal of conv_pass_sequencer:
//               host command channel, filter/IFmap streams, design_top core
//               strobes and status, result stream and pass status flags.
//               master : sequencer side      slave : host + core side
// Ports       : cmd_*   pass command (valid/ready + fields)
//               filt_*  filter word stream      if_*  IFmap word stream
//               core_*  design_top control, FIFO writes, output-buffer reads
//               res_*   registered result stream
//               busy / done / timeout_err  pass status
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface conv_pass_sequencer_if #(
   parameter int FILT_W = 16,
   parameter int IF_W   = 18,
   parameter int OUT_W  = 33,
   parameter int CNT_W  = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_mode;
   logic [3:0]        cmd_filt_len;
   logic [3:0]        cmd_stride;
   logic [CNT_W-1:0]  cmd_n_filt;
   logic [CNT_W-1:0]  cmd_n_if;
   logic [CNT_W-1:0]  cmd_n_out;

   logic              filt_valid;
   logic              filt_ready;
   logic [FILT_W-1:0] filt_data;
   logic              if_valid;
   logic              if_ready;
   logic [IF_W-1:0]   if_data;

   logic              core_start;
   logic [1:0]        core_mode;
   logic [3:0]        core_filt_len;
   logic [3:0]        core_stride_len;
   logic              core_filter_wen;
   logic [FILT_W-1:0] core_filter_din;
   logic              core_filter_full;
   logic              core_IF_wen;
   logic [IF_W-1:0]   core_IF_din;
   logic              core_IF_full;
   logic              core_ready_to_get;
   logic              core_outbuf_write_flag;
   logic              core_inpsum_buf_wen;
   logic              core_inpsum_buf_full;
   logic              core_outbuf_ren;
   logic              core_outbuf_empty;
   logic [OUT_W-1:0]  core_outbuf_dout;

   logic              res_valid;
   logic              res_ready;
   logic [OUT_W-1:0]  res_data;

   logic              busy;
   logic              done;
   logic              timeout_err;

   modport master (
      input  cmd_valid, cmd_mode, cmd_filt_len, cmd_stride, cmd_n_filt, cmd_n_if, cmd_n_out,
      input  filt_valid, filt_data, if_valid, if_data,
      input  core_filter_full, core_IF_full, core_ready_to_get, core_inpsum_buf_full,
      input  core_outbuf_empty, core_outbuf_dout, res_ready,
      output cmd_ready, filt_ready, if_ready,
      output core_start, core_mode, core_filt_len, core_stride_len,
      output core_filter_wen, core_filter_din, core_IF_wen, core_IF_din,
      output core_outbuf_write_flag, core_inpsum_buf_wen, core_outbuf_ren,
      output res_valid, res_data, busy, done, timeout_err
   );

   modport slave (
      output cmd_valid, cmd_mode, cmd_filt_len, cmd_stride, cmd_n_filt, cmd_n_if, cmd_n_out,
      output filt_valid, filt_data, if_valid, if_data,
      output core_filter_full, core_IF_full, core_ready_to_get, core_inpsum_buf_full,
      output core_outbuf_empty, core_outbuf_dout, res_ready,
      input  cmd_ready, filt_ready, if_ready,
      input  core_start, core_mode, core_filt_len, core_stride_len,
      input  core_filter_wen, core_filter_din, core_IF_wen, core_IF_din,
      input  core_outbuf_write_flag, core_inpsum_buf_wen, core_outbuf_ren,
      input  res_valid, res_data, busy, done, timeout_err
   );
endinterface

`default_nettype wire

// File: rtl/conv_pass_sequencer.sv
// ============================================================================
// Module      : conv_pass_sequencer
// Description : Sequences one convolution pass of design_top: accepts a pass
//               command, streams filter and IFmap words into the core FIFOs,
//               waits for ready_to_get (with watchdog), then drains the output
//               buffer onto a registered valid/ready result port.
// Ports       : clk    clock
//               rst_n  asynchronous active-low reset
//               bus    conv_pass_sequencer_if.master (command, streams, core
//                      strobes, result stream, busy/done/timeout_err)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_pass_sequencer #(
   parameter int FILT_W = 16,
   parameter int IF_W   = 18,
   parameter int OUT_W  = 33,
   parameter int CNT_W  = 8,
   parameter int TMO_W  = 16
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   conv_pass_sequencer_if.master   bus
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_START    = 3'd1;
   localparam logic [2:0] S_LOAD     = 3'd2;
   localparam logic [2:0] S_WAIT_RDY = 3'd3;
   localparam logic [2:0] S_DRAIN    = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0] C_WD_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

   logic [2:0]        r_state;
   logic [1:0]        r_mode;
   logic [3:0]        r_filt_len;
   logic [3:0]        r_stride;
   logic [CNT_W-1:0]  r_n_filt, r_n_if, r_n_out;
   logic [CNT_W-1:0]  r_filt_cnt, r_if_cnt, r_out_cnt;
   logic [TMO_W-1:0]  r_wd;
   logic              r_timeout;
   logic              r_psum_pend;   // entry psum-buffer pulse still owed
   logic              r_res_valid;
   logic [OUT_W-1:0]  r_res_data;

   logic              w_in_load, w_in_drain, w_mode3;
   logic              w_filt_ready, w_filt_fire, w_if_ready, w_if_fire;
   logic              w_load_done, w_ren, w_psum_wen;
   logic [TMO_W-1:0]  w_wd_next;

   assign w_in_load    = (r_state == S_LOAD);
   assign w_in_drain   = (r_state == S_DRAIN);
   assign w_mode3      = (r_mode == 2'd3);

   assign w_filt_ready = w_in_load & (r_filt_cnt < r_n_filt) & ~bus.core_filter_full;
   assign w_filt_fire  = w_filt_ready & bus.filt_valid;
   assign w_if_ready   = w_in_load & (r_if_cnt < r_n_if) & ~bus.core_IF_full;
   assign w_if_fire    = w_if_ready & bus.if_valid;
   assign w_load_done  = (r_filt_cnt == r_n_filt) & (r_if_cnt == r_n_if);

   // In mode 3 every read needs a matching psum-buffer write in the same
   // cycle, and the entry pulse is issued on its own before the first read.
   assign w_ren = w_in_drain & ~bus.core_outbuf_empty & (r_out_cnt < r_n_out)
                & (~r_res_valid | bus.res_ready)
                & (~w_mode3 | (~bus.core_inpsum_buf_full & ~r_psum_pend));
   assign w_psum_wen = w_in_drain & w_mode3 & ~bus.core_inpsum_buf_full
                     & (r_psum_pend | w_ren);

   assign w_wd_next = r_wd + C_WD_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mode      <= 2'd0;
         r_filt_len  <= 4'd0;
         r_stride    <= 4'd0;
         r_n_filt    <= '0;
         r_n_if      <= '0;
         r_n_out     <= '0;
         r_filt_cnt  <= '0;
         r_if_cnt    <= '0;
         r_out_cnt   <= '0;
         r_wd        <= '0;
         r_timeout   <= 1'b0;
         r_psum_pend <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         if (w_filt_fire) r_filt_cnt <= r_filt_cnt + C_CNT_ONE;
         if (w_if_fire)   r_if_cnt   <= r_if_cnt + C_CNT_ONE;
         if (w_ren)       r_out_cnt  <= r_out_cnt + C_CNT_ONE;
         if (w_psum_wen & r_psum_pend) r_psum_pend <= 1'b0;

         // Result register: a capture wins over a handshake so back-to-back
         // transfers keep res_valid high; data only changes on capture.
         if (w_ren) begin
            r_res_data  <= bus.core_outbuf_dout;
            r_res_valid <= 1'b1;
         end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_mode     <= bus.cmd_mode;
                  r_filt_len <= bus.cmd_filt_len;
                  r_stride   <= bus.cmd_stride;
                  r_n_filt   <= bus.cmd_n_filt;
                  r_n_if     <= bus.cmd_n_if;
                  r_n_out    <= bus.cmd_n_out;
                  r_filt_cnt <= '0;
                  r_if_cnt   <= '0;
                  r_out_cnt  <= '0;
                  r_wd       <= '0;
                  r_timeout  <= 1'b0;
                  r_state    <= S_START;
               end
            end
            S_START: r_state <= S_LOAD;
            S_LOAD: begin
               if (w_load_done) begin
                  r_wd    <= '0;
                  r_state <= S_WAIT_RDY;
               end
            end
            S_WAIT_RDY: begin
               if (bus.core_ready_to_get) begin
                  r_wd        <= '0;
                  r_psum_pend <= w_mode3;
                  r_state     <= S_DRAIN;
               end else if (&w_wd_next) begin
                  r_wd      <= '0;
                  r_timeout <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_wd <= w_wd_next;
               end
            end
            S_DRAIN: begin
               if ((r_out_cnt == r_n_out) & ~r_res_valid & ~r_psum_pend)
                  r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from state so an asynchronous reset drops them at once.
   assign bus.cmd_ready              = (r_state == S_IDLE);
   assign bus.filt_ready             = w_filt_ready;
   assign bus.if_ready               = w_if_ready;
   assign bus.core_start             = (r_state == S_START);
   assign bus.core_mode              = r_mode;
   assign bus.core_filt_len          = r_filt_len;
   assign bus.core_stride_len        = r_stride;
   assign bus.core_filter_wen        = w_filt_fire;
   assign bus.core_filter_din        = w_in_load ? bus.filt_data : '0;
   assign bus.core_IF_wen            = w_if_fire;
   assign bus.core_IF_din            = w_in_load ? bus.if_data : '0;
   assign bus.core_outbuf_write_flag = w_in_drain;
   assign bus.core_inpsum_buf_wen    = w_psum_wen;
   assign bus.core_outbuf_ren        = w_ren;
   assign bus.res_valid              = r_res_valid;
   assign bus.res_data               = r_res_data;
   assign bus.busy                   = (r_state != S_IDLE);
   assign bus.done                   = (r_state == S_DONE);
   assign bus.timeout_err            = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_conv_pass_sequencer.sv
// ============================================================================
// Module      : tb_conv_pass_sequencer
// Description : Self-checking bench for conv_pass_sequencer. Models the host
//               streams, a first-word-fall-through output buffer and a result
//               sink; expected words are queued when driven and compared when
//               the sequencer produces them.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_pass_sequencer;
   localparam int FILT_W  = 16;
   localparam int IF_W    = 18;
   localparam int OUT_W   = 33;
   localparam int CNT_W   = 8;
   localparam int TMO_W   = 10;
   // START (1) + LOAD with nothing to load (1) + WAIT_RDY (2^TMO_W - 1)
   localparam int TMO_CYC = (1 << TMO_W) + 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   conv_pass_sequencer_if #(.FILT_W(FILT_W), .IF_W(IF_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) sif ();

   conv_pass_sequencer #(
      .FILT_W(FILT_W), .IF_W(IF_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int filt_vals [6]  = '{-130, -53, 177, -120, -121, 25};
   int if_vals   [10] = '{0, 0, -1, 2, -1, -2, 2, 0, 1, 1};
   int out_vals  [5]  = '{-346, 819, -155, -776, 494};

   logic [FILT_W-1:0] fexp_q [$];
   logic [IF_W-1:0]   iexp_q [$];
   logic [OUT_W-1:0]  rexp_q [$];
   logic [OUT_W-1:0]  ob_q   [$];

   // monitor state (written only by the negedge monitor)
   bit f_fire, i_fire, r_fire, ob_pop;
   int n_fwen, n_iwen, n_psum, n_ren, n_done, n_full_viol, n_full_cyc;
   int n_stall_viol, n_stall_cyc, n_wf_viol, n_wf_high, n_hs_viol;
   int cyc, start_cyc, done_cyc;
   bit to_at_done, to_at_start, stall_prev;
   logic [OUT_W-1:0] stall_data;
   logic [1:0] exp_mode;
   logic [3:0] exp_fl, exp_st;

   // bench control
   bit stall_mode;
   int stall_cnt;
   int ob_fill;
   bit ob_clear;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         f_fire = sif.filt_valid & sif.filt_ready;
         i_fire = sif.if_valid & sif.if_ready;
         r_fire = sif.res_valid & sif.res_ready;
         ob_pop = sif.core_outbuf_ren;
         if (sif.core_filter_wen != f_fire || sif.core_IF_wen != i_fire) n_hs_viol++;
         if (sif.core_filter_wen) begin
            n_fwen++;
            if (fexp_q.size() == 0) check("filt_wen_extra", 1, 0);
            else check("filt_din", sif.core_filter_din, fexp_q.pop_front());
         end
         if (sif.core_IF_wen) begin
            n_iwen++;
            if (iexp_q.size() == 0) check("if_wen_extra", 1, 0);
            else check("if_din", sif.core_IF_din, iexp_q.pop_front());
         end
         if (sif.core_inpsum_buf_wen) n_psum++;
         if (sif.core_outbuf_ren) n_ren++;
         if (sif.core_IF_full) begin
            n_full_cyc++;
            if (sif.if_ready || sif.core_IF_wen) n_full_viol++;
         end
         if (sif.res_valid && !sif.res_ready) begin
            n_stall_cyc++;
            if (sif.core_outbuf_ren) n_stall_viol++;
            if (stall_prev && sif.res_data !== stall_data) n_stall_viol++;
            stall_prev = 1'b1;
            stall_data = sif.res_data;
         end else begin
            stall_prev = 1'b0;
         end
         if (r_fire) begin
            if (rexp_q.size() == 0) check("res_extra", 1, 0);
            else check("res_data", sif.res_data, rexp_q.pop_front());
         end
         if (sif.core_outbuf_write_flag) begin
            n_wf_high++;
            if (sif.core_start || sif.done || sif.cmd_ready) n_wf_viol++;
         end
         if (sif.core_outbuf_ren && !sif.core_outbuf_write_flag) n_wf_viol++;
         if (sif.core_start) begin
            start_cyc   = cyc;
            to_at_start = sif.timeout_err;
            check("core_mode", sif.core_mode, exp_mode);
            check("core_filt_len", sif.core_filt_len, exp_fl);
            check("core_stride_len", sif.core_stride_len, exp_st);
         end
         if (sif.done) begin
            n_done++;
            done_cyc   = cyc;
            to_at_done = sif.timeout_err;
         end
      end
   end

   // FWFT output buffer model: pops the word read in the previous cycle
   always @(posedge clk) begin
      #1;
      if (ob_clear) begin
         ob_q.delete();
         ob_clear = 1'b0;
      end
      if (ob_pop && ob_q.size() != 0) void'(ob_q.pop_front());
      ob_pop = 1'b0;
      if (ob_fill > 0) begin
         for (int k = 0; k < ob_fill; k++) ob_q.push_back(OUT_W'(out_vals[k]));
         ob_fill = 0;
      end
      sif.core_outbuf_empty = (ob_q.size() == 0);
      sif.core_outbuf_dout  = (ob_q.size() != 0) ? ob_q[0] : '0;
   end

   // result sink: always ready, or holds ready low 4 cycles per word
   always @(posedge clk) begin
      #1;
      if (!stall_mode) begin
         stall_cnt = 0;
         sif.res_ready = 1'b1;
      end else begin
         if (r_fire) stall_cnt = 0;
         else if (sif.res_valid) stall_cnt++;
         sif.res_ready = (stall_cnt >= 4);
      end
   end

   function automatic logic [IF_W-1:0] if_word(input int k);
      logic [1:0] tag;
      int v;
      tag = (k == 0) ? 2'b10 : ((k == 9) ? 2'b01 : 2'b00);
      v   = if_vals[k];
      return {tag, v[15:0]};
   endfunction

   task automatic wait_cmd_ready();
      for (int c = 0; c < 50; c++) begin
         if (sif.cmd_ready) return;
         @(posedge clk); #1;
      end
      check("cmd_ready_timeout", 0, 1);
   endtask

   task automatic run_pass(input logic [1:0] mode, input int nf, input int ni, input int nout,
                           input bit full_test, input bit give_rtg,
                           output int d_fwen, output int d_iwen, output int d_psum,
                           output int d_ren, output int d_done);
      int b_fwen, b_iwen, b_psum, b_ren, b_done, bound;
      bit ok;
      wait_cmd_ready();
      b_fwen = n_fwen; b_iwen = n_iwen; b_psum = n_psum; b_ren = n_ren; b_done = n_done;
      exp_mode = mode; exp_fl = 4'd3; exp_st = 4'd1;
      sif.cmd_mode     = mode;
      sif.cmd_filt_len = 4'd3;
      sif.cmd_stride   = 4'd1;
      sif.cmd_n_filt   = CNT_W'(nf);
      sif.cmd_n_if     = CNT_W'(ni);
      sif.cmd_n_out    = CNT_W'(nout);
      sif.cmd_valid    = 1'b1;
      @(posedge clk); #1;
      sif.cmd_valid    = 1'b0;
      fork
         begin
            for (int k = 0; k < nf; k++) begin
               sif.filt_valid = 1'b1;
               sif.filt_data  = FILT_W'(filt_vals[k]);
               fexp_q.push_back(FILT_W'(filt_vals[k]));
               ok = 1'b0;
               for (int c = 0; c < 200 && !ok; c++) begin
                  @(posedge clk); #1;
                  ok = f_fire;
               end
               if (!ok) check("filt_hs_timeout", 0, 1);
            end
            sif.filt_valid = 1'b0;
         end
         begin
            for (int k = 0; k < ni; k++) begin
               sif.if_valid = 1'b1;
               sif.if_data  = if_word(k);
               iexp_q.push_back(if_word(k));
               for (int c = 0; c < 200; c++) begin
                  @(posedge clk); #1;
                  if (i_fire) break;
                  if (c == 199) check("if_hs_timeout", 0, 1);
               end
            end
            sif.if_valid = 1'b0;
         end
         begin
            if (full_test) begin
               for (int c = 0; c < 200 && (n_iwen - b_iwen) < 3; c++) begin
                  @(posedge clk); #1;
               end
               sif.core_IF_full = 1'b1;
               repeat (5) begin @(posedge clk); #1; end
               sif.core_IF_full = 1'b0;
            end
         end
      join
      ob_fill = nout;
      if (give_rtg) begin
         for (int k = 0; k < nout; k++) rexp_q.push_back(OUT_W'(out_vals[k]));
         repeat (3) begin @(posedge clk); #1; end
         sif.core_ready_to_get = 1'b1;
      end
      bound = give_rtg ? 500 : TMO_CYC + 100;
      ok = 1'b0;
      for (int c = 0; c < bound && !ok; c++) begin
         @(posedge clk); #1;
         ok = (n_done != b_done);
      end
      if (!ok) check("done_timeout", 0, 1);
      sif.core_ready_to_get = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      d_fwen = n_fwen - b_fwen; d_iwen = n_iwen - b_iwen; d_psum = n_psum - b_psum;
      d_ren  = n_ren - b_ren;   d_done = n_done - b_done;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d_fwen, d_iwen, d_psum, d_ren, d_done, b_stall, b_sv, b_fv, b_fc, b_wv, b_wh;
      rst_n = 1'b0;
      sif.cmd_valid = 1'b0; sif.cmd_mode = 2'd0; sif.cmd_filt_len = 4'd0; sif.cmd_stride = 4'd0;
      sif.cmd_n_filt = '0; sif.cmd_n_if = '0; sif.cmd_n_out = '0;
      sif.filt_valid = 1'b0; sif.filt_data = '0; sif.if_valid = 1'b0; sif.if_data = '0;
      sif.core_filter_full = 1'b0; sif.core_IF_full = 1'b0;
      sif.core_ready_to_get = 1'b0; sif.core_inpsum_buf_full = 1'b0;
      stall_mode = 1'b0; ob_fill = 0; ob_clear = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_cmd_ready", sif.cmd_ready, 1);
      check("rst_busy", sif.busy, 0);
      check("rst_res_valid", sif.res_valid, 0);
      check("rst_start_done_to", {sif.core_start, sif.done, sif.timeout_err}, 3'b000);
      check("rst_write_flag", sif.core_outbuf_write_flag, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // mode 3 pass, result sink always ready
      run_pass(2'd3, 6, 10, 5, 1'b0, 1'b1, d_fwen, d_iwen, d_psum, d_ren, d_done);
      check("m3_filter_wen", d_fwen, 6);
      check("m3_if_wen", d_iwen, 10);
      check("m3_inpsum_wen", d_psum, 6);
      check("m3_ren", d_ren, 5);
      check("m3_done", d_done, 1);
      check("m3_res_left", rexp_q.size(), 0);

      // same pass with result back-pressure
      b_stall = n_stall_cyc; b_sv = n_stall_viol;
      stall_mode = 1'b1;
      run_pass(2'd3, 6, 10, 5, 1'b0, 1'b1, d_fwen, d_iwen, d_psum, d_ren, d_done);
      stall_mode = 1'b0;
      check("stall_seen", (n_stall_cyc - b_stall) >= 15, 1);
      check("stall_violations", n_stall_viol - b_sv, 0);
      check("stall_ren", d_ren, 5);
      check("stall_res_left", rexp_q.size(), 0);

      // IF FIFO full for 5 cycles mid-load
      b_fv = n_full_viol; b_fc = n_full_cyc;
      run_pass(2'd3, 6, 10, 5, 1'b1, 1'b1, d_fwen, d_iwen, d_psum, d_ren, d_done);
      check("full_cycles", n_full_cyc - b_fc, 5);
      check("full_violations", n_full_viol - b_fv, 0);
      check("full_if_wen", d_iwen, 10);
      check("full_done", d_done, 1);

      // ready_to_get never arrives
      run_pass(2'd2, 0, 0, 5, 1'b0, 1'b0, d_fwen, d_iwen, d_psum, d_ren, d_done);
      check("tmo_cycles", done_cyc - start_cyc, TMO_CYC);
      check("tmo_err_at_done", to_at_done, 1);
      check("tmo_done", d_done, 1);
      check("tmo_ren", d_ren, 0);
      check("tmo_sticky", sif.timeout_err, 1);
      ob_clear = 1'b1;
      @(posedge clk); #1;

      // mode 1 pass
      b_wv = n_wf_viol; b_wh = n_wf_high;
      run_pass(2'd1, 6, 10, 5, 1'b0, 1'b1, d_fwen, d_iwen, d_psum, d_ren, d_done);
      check("m1_timeout_cleared", to_at_start, 0);
      check("m1_inpsum_wen", d_psum, 0);
      check("m1_ren", d_ren, 5);
      check("m1_wflag_seen", (n_wf_high - b_wh) > 0, 1);
      check("m1_wflag_violations", n_wf_viol - b_wv, 0);
      check("m1_res_left", rexp_q.size(), 0);
      check("hs_wen_mismatch", n_hs_viol, 0);

      // reset while in LOAD
      wait_cmd_ready();
      exp_mode = 2'd3; exp_fl = 4'd3; exp_st = 4'd1;
      sif.cmd_mode = 2'd3; sif.cmd_n_filt = 8'd6; sif.cmd_n_if = 8'd10; sif.cmd_n_out = 8'd5;
      sif.cmd_valid = 1'b1;
      @(posedge clk); #1;
      sif.cmd_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("load_filt_ready", sif.filt_ready, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_cmd_ready", sif.cmd_ready, 1);
      check("mid_rst_busy", sif.busy, 0);
      check("mid_rst_ready", {sif.filt_ready, sif.if_ready}, 2'b00);
      check("mid_rst_core_mode", sif.core_mode, 0);
      check("mid_rst_strobes", {sif.core_start, sif.core_outbuf_write_flag, sif.res_valid, sif.done}, 4'b0000);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
